// File: rtl/commit_trace_buffer.sv
// Retire-trace capture stage: classifies qualified commits into trace records and
// buffers them in a drop-on-overflow FIFO drained over a valid/ready handshake.
package riscv_pkg;
    localparam int unsigned XLEN = 32;

    typedef enum logic [5:0] {
        OP_NOP, OP_ADD, OP_ADDI, OP_LUI, OP_JAL, OP_BEQ,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW
    } operation_e;
endpackage

module commit_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned XLEN  = riscv_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       update_i,
    input  logic [XLEN-1:0]            pc_i,
    input  logic [XLEN-1:0]            instr_i,
    input  logic [4:0]                 reg_addr_i,
    input  logic [XLEN-1:0]            reg_data_i,
    input  logic                       register_file_write_enable_i,
    input  logic                       memory_read_enable_i,
    input  logic                       memory_write_enable_i,
    input  logic [XLEN-1:0]            memory_read_addr_i,
    input  logic [XLEN-1:0]            memory_write_addr_i,
    input  logic [XLEN-1:0]            memory_write_data_i,
    input  riscv_pkg::operation_e      operation_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [1:0]                 trace_kind_o,
    output logic [31:0]                trace_seq_o,
    output logic [XLEN-1:0]            trace_pc_o,
    output logic [XLEN-1:0]            trace_instr_o,
    output logic [4:0]                 trace_rd_o,
    output logic [XLEN-1:0]            trace_data_o,
    output logic [XLEN-1:0]            trace_addr_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_count_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef struct packed {
        logic [1:0]      kind;
        logic [31:0]     seq;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] addr;
    } rec_t;

    rec_t          mem_q [DEPTH];
    rec_t          new_rec;
    rec_t          head;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]   seq_q, seq_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q, drop_d;
    logic          qualified, empty, full, push, pop, drop;

    always_comb begin
        new_rec       = '0;
        new_rec.seq   = seq_q;
        new_rec.pc    = pc_i;
        new_rec.instr = instr_i;
        if (memory_write_enable_i) begin
            new_rec.kind = 2'd3;
            new_rec.addr = memory_write_addr_i;
            unique case (operation_i)
                riscv_pkg::OP_SW: new_rec.data = memory_write_data_i;
                riscv_pkg::OP_SH: new_rec.data = XLEN'(memory_write_data_i[15:0]);
                riscv_pkg::OP_SB: new_rec.data = XLEN'(memory_write_data_i[7:0]);
                default:          new_rec.data = '0;
            endcase
        end else if (memory_read_enable_i) begin
            // A load to x0 still retires but carries nothing worth tracing.
            if (reg_addr_i != 5'd0) begin
                new_rec.kind = 2'd2;
                new_rec.rd   = reg_addr_i;
                new_rec.data = reg_data_i;
                new_rec.addr = memory_read_addr_i;
            end
        end else if (register_file_write_enable_i && reg_addr_i != 5'd0) begin
            new_rec.kind = 2'd1;
            new_rec.rd   = reg_addr_i;
            new_rec.data = reg_data_i;
        end
    end

    assign qualified = update_i && (pc_i != '0);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop       = !empty && trace_ready_i;
    assign push      = qualified && (!full || pop);
    assign drop      = qualified && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (push)      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)       rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (qualified) seq_d    = seq_q + 32'd1;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= new_rec;
    end

    // Storage is not reset, so the head is masked whenever the FIFO is empty.
    assign head          = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign trace_valid_o = !empty;
    assign trace_kind_o  = head.kind;
    assign trace_seq_o   = head.seq;
    assign trace_pc_o    = head.pc;
    assign trace_instr_o = head.instr;
    assign trace_rd_o    = head.rd;
    assign trace_data_o  = head.data;
    assign trace_addr_o  = head.addr;
    assign overflow_o    = overflow_q;
    assign drop_count_o  = drop_q;
    assign level_o       = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed and scoreboarded checks for commit_trace_buffer (DEPTH=16, XLEN=32).
module tb_commit_trace_buffer;
    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] seq;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] addr;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        update;
    logic [31:0] pc, instr, rdata, raddr, waddr, wdata;
    logic [4:0]  rd;
    logic        rfwe, mre, mwe, ready;
    riscv_pkg::operation_e op;
    logic        valid, overflow;
    logic [1:0]  kind;
    logic [31:0] seq_o, pc_o, instr_o, data_o, addr_o;
    logic [4:0]  rd_o;
    logic [15:0] drops;
    logic [4:0]  level;
    rec_t        dut_rec;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(16), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .update_i(update), .pc_i(pc), .instr_i(instr),
        .reg_addr_i(rd), .reg_data_i(rdata), .register_file_write_enable_i(rfwe),
        .memory_read_enable_i(mre), .memory_write_enable_i(mwe),
        .memory_read_addr_i(raddr), .memory_write_addr_i(waddr),
        .memory_write_data_i(wdata), .operation_i(op),
        .trace_valid_o(valid), .trace_ready_i(ready), .trace_kind_o(kind),
        .trace_seq_o(seq_o), .trace_pc_o(pc_o), .trace_instr_o(instr_o),
        .trace_rd_o(rd_o), .trace_data_o(data_o), .trace_addr_o(addr_o),
        .overflow_o(overflow), .drop_count_o(drops), .level_o(level)
    );

    assign dut_rec = {kind, seq_o, pc_o, instr_o, rd_o, data_o, addr_o};

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        update = 0; pc = 0; instr = 0; rd = 0; rdata = 0; rfwe = 0; mre = 0; mwe = 0;
        raddr = 0; waddr = 0; wdata = 0; op = riscv_pkg::OP_NOP;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] ins, input logic [4:0] r,
                         input logic [31:0] rv, input logic we, input logic ld, input logic st,
                         input logic [31:0] a, input logic [31:0] wd, input riscv_pkg::operation_e o);
        update = 1; pc = p; instr = ins; rd = r; rdata = rv; rfwe = we; mre = ld; mwe = st;
        raddr = st ? 32'h1111_0000 : a;
        waddr = st ? a : 32'h2222_0000;
        wdata = wd; op = o;
    endtask

    function automatic rec_t mk(input logic [1:0] k, input logic [31:0] s, input logic [31:0] p,
                                input logic [31:0] ins, input logic [4:0] r,
                                input logic [31:0] d, input logic [31:0] a);
        rec_t x;
        x.kind = k; x.seq = s; x.pc = p; x.instr = ins; x.rd = r; x.data = d; x.addr = a;
        return x;
    endfunction

    task automatic pop1();
        ready = 1; step(); ready = 0;
    endtask

    rec_t q[$];
    rec_t e;

    initial begin
        int unsigned mseq, mdrops, c;
        logic [4:0]  rr;
        logic [31:0] dd, aa, pp;
        logic        rdy, do_pop, was_full;

        idle();
        ready = 0;
        rst = 1;
        update = 1; pc = 32'h8000_0000; rfwe = 1; rd = 3; rdata = 32'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_valid", valid, 0);
            chk("rst_rec", dut_rec, '0);
            chk("rst_level", level, 0);
            chk("rst_ovf_drops", {overflow, drops}, 0);
        end
        rst = 0;
        idle();

        // addi x5 -> kind 1; no bypass before the edge
        drive(32'h8000_0000, 32'h0120_0293, 5, 32'h12, 1, 0, 0, 0, 0, riscv_pkg::OP_ADDI);
        #1 chk("no_bypass", valid, 0);
        step(); idle();
        chk("addi_valid", valid, 1);
        chk("addi_rec", dut_rec, mk(1, 0, 32'h8000_0000, 32'h0120_0293, 5, 32'h12, 0));
        chk("addi_level", level, 1);
        step();
        chk("hold_no_ready", dut_rec, mk(1, 0, 32'h8000_0000, 32'h0120_0293, 5, 32'h12, 0));
        pop1();
        chk("pop_empty", {valid, level}, 0);

        drive(32'h8000_0004, 32'h0000_2503, 10, 32'hCAFE, 1, 1, 0, 32'h8000_1000, 0, riscv_pkg::OP_LW);
        step(); idle();
        chk("load_rec", dut_rec, mk(2, 1, 32'h8000_0004, 32'h0000_2503, 10, 32'hCAFE, 32'h8000_1000));
        pop1();

        drive(32'h8000_0008, 32'h0000_2003, 0, 32'hBEEF, 1, 1, 0, 32'h8000_1004, 0, riscv_pkg::OP_LW);
        step(); idle();
        chk("load_x0_rec", dut_rec, mk(0, 2, 32'h8000_0008, 32'h0000_2003, 0, 0, 0));
        pop1();

        drive(32'h0, 32'h0000_0013, 6, 32'h5, 1, 0, 0, 0, 0, riscv_pkg::OP_ADDI);
        step(); idle();
        chk("pc0_ignored", {valid, level}, 0);

        drive(32'h8000_0010, 32'h00A1_0023, 7, 32'h99, 1, 0, 1, 32'h8000_2000, 32'hDEAD_BEEF, riscv_pkg::OP_SB);
        step(); idle();
        chk("sb_rec", dut_rec, mk(3, 3, 32'h8000_0010, 32'h00A1_0023, 0, 32'h0000_00EF, 32'h8000_2000));
        pop1();
        drive(32'h8000_0014, 32'h00A1_1023, 0, 0, 0, 0, 1, 32'h8000_2002, 32'hDEAD_BEEF, riscv_pkg::OP_SH);
        step(); idle();
        chk("sh_rec", dut_rec, mk(3, 4, 32'h8000_0014, 32'h00A1_1023, 0, 32'h0000_BEEF, 32'h8000_2002));
        pop1();
        drive(32'h8000_0018, 32'h00A1_2023, 0, 0, 0, 0, 1, 32'h8000_2004, 32'hDEAD_BEEF, riscv_pkg::OP_SW);
        step(); idle();
        chk("sw_rec", dut_rec, mk(3, 5, 32'h8000_0018, 32'h00A1_2023, 0, 32'hDEAD_BEEF, 32'h8000_2004));
        pop1();
        drive(32'h8000_001C, 32'h0000_0013, 0, 0, 0, 0, 1, 32'h8000_2008, 32'hDEAD_BEEF, riscv_pkg::OP_ADDI);
        step(); idle();
        chk("st_other_rec", dut_rec, mk(3, 6, 32'h8000_001C, 32'h0000_0013, 0, 0, 32'h8000_2008));
        pop1();

        // overflow: 20 commits into 16 entries with no sink
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 20; i++) begin
            drive(32'h8000_1000 + 4 * i, 32'h13, 1, i, 1, 0, 0, 0, 0, riscv_pkg::OP_ADDI);
            step();
        end
        idle();
        chk("ovf_level", level, 16);
        chk("ovf_drops", drops, 4);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            chk("drain_rec", dut_rec, mk(1, i, 32'h8000_1000 + 4 * i, 32'h13, 1, i, 0));
            pop1();
        end
        chk("drain_level", {valid, level}, 0);
        drive(32'h8000_2000, 32'h13, 2, 32'h42, 1, 0, 0, 0, 0, riscv_pkg::OP_ADDI);
        step(); idle();
        chk("after_ovf_seq", seq_o, 20);
        pop1();

        // full with a pop every cycle: seq 21..36 fill, 37..86 streamed
        for (int i = 0; i < 16; i++) begin
            drive(32'h8000_3000 + 4 * i, 32'h13, 3, i, 1, 0, 0, 0, 0, riscv_pkg::OP_ADDI);
            step();
        end
        idle();
        chk("full_level", level, 16);
        ready = 1;
        for (int i = 0; i < 50; i++) begin
            drive(32'h8000_4000 + 4 * i, 32'h13, 3, i, 1, 0, 0, 0, 0, riscv_pkg::OP_ADDI);
            chk("stream_seq", seq_o, 21 + i);
            chk("stream_level", level, 16);
            step();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            chk("stream_tail_seq", seq_o, 71 + i);
            step();
        end
        ready = 0;
        chk("stream_end", {valid, level}, 0);
        chk("stream_drops", drops, 4);

        // scoreboard with random backpressure
        rst = 1; step(); rst = 0;
        chk("rst_clears_ovf", {overflow, drops}, 0);
        mseq = 0; mdrops = 0;
        for (int i = 0; i < 1000; i++) begin
            c  = $urandom_range(0, 3);
            rr = 5'($urandom_range(1, 31));
            dd = $urandom;
            aa = 32'h9000_0000 | ($urandom & 32'hFFFC);
            pp = 32'h8001_0000 + 4 * i;
            rdy = 1'($urandom_range(0, 1));
            case (c)
                0: begin
                    drive(pp, 32'h13, rr, dd, 1, 0, 0, 0, 0, riscv_pkg::OP_ADDI);
                    e = mk(1, mseq, pp, 32'h13, rr, dd, 0);
                end
                1: begin
                    drive(pp, 32'h2003, rr, dd, 1, 1, 0, aa, 0, riscv_pkg::OP_LW);
                    e = mk(2, mseq, pp, 32'h2003, rr, dd, aa);
                end
                2: begin
                    drive(pp, 32'h2023, rr, 0, 0, 0, 1, aa, dd, riscv_pkg::OP_SW);
                    e = mk(3, mseq, pp, 32'h2023, 0, dd, aa);
                end
                default: begin
                    drive(pp, 32'h0023, rr, 0, 0, 0, 1, aa, dd, riscv_pkg::OP_SB);
                    e = mk(3, mseq, pp, 32'h0023, 0, {24'd0, dd[7:0]}, aa);
                end
            endcase
            ready = rdy;
            #1;
            chk("sb_valid", valid, q.size() != 0);
            chk("sb_level", level, q.size());
            if (q.size() != 0) chk("sb_rec", dut_rec, q[0]);
            was_full = (q.size() == 16);
            do_pop   = rdy && (q.size() != 0);
            if (do_pop) void'(q.pop_front());
            if (!was_full || do_pop) q.push_back(e);
            else mdrops++;
            mseq++;
            step();
        end
        idle();
        ready = 0;
        chk("sb_drops", drops, mdrops);
        chk("sb_ovf", overflow, mdrops != 0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) begin
            drive(32'h8002_0000 + 4 * i, 32'h13, 4, i, 1, 0, 0, 0, 0, riscv_pkg::OP_ADDI);
            step();
        end
        idle();
        chk("pre_rst_valid", valid, 1);
        rst = 1;
        #1;
        chk("async_rst_empty", {valid, level}, 0);
        chk("async_rst_rec", dut_rec, '0);
        step(); rst = 0;
        drive(32'h8003_0000, 32'h13, 9, 32'h5A, 1, 0, 0, 0, 0, riscv_pkg::OP_ADDI);
        step(); idle();
        chk("post_rst_rec", dut_rec, mk(1, 0, 32'h8003_0000, 32'h13, 9, 32'h5A, 0));
        chk("post_rst_level", level, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Hardware retire-trace capture stage sitting directly downstream of `core_model`'s commit/debug outputs. Each cycle with `update_i` high, it classifies the retired instruction (plain, register write, load, store), masks store data to the access size, tags it with a sequence number, and pushes a record into a FIFO. Records drain over a valid/ready interface to a trace sink (UART formatter, log dumper or lockstep comparator). Overflow drops are counted rather than stalling the core.

## Interface
- `DEPTH`, 16: FIFO entries, power of two, at least 2.
- `XLEN`, `riscv_pkg::XLEN` (32): datapath width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `update_i` input 1: retire strobe from core.
- `pc_i`, `instr_i` input XLEN: retired PC and instruction word.
- `reg_addr_i` input 5: destination register.
- `reg_data_i` input XLEN: writeback value.
- `register_file_write_enable_i` input 1: RF write.
- `memory_read_enable_i`, `memory_write_enable_i` input 1: load or store.
- `memory_read_addr_i`, `memory_write_addr_i`, `memory_write_data_i` input XLEN: memory access fields.
- `operation_i` input `riscv_pkg::operation_e`: decoded operation, used for store size.
- `trace_valid_o` output 1: head record valid.
- `trace_ready_i` input 1: sink accepts the head record.
- `trace_kind_o` output 2: 0 plain, 1 reg write, 2 load, 3 store.
- `trace_seq_o` output 32: sequence number of the record.
- `trace_pc_o`, `trace_instr_o` output XLEN: PC and instruction of the record.
- `trace_rd_o` output 5: destination register (0 unless kind is 1 or 2).
- `trace_data_o` output XLEN: register data or masked store data.
- `trace_addr_o` output XLEN: memory address (0 for kinds 0 and 1).
- `overflow_o` output 1: sticky, set on the first dropped record.
- `drop_count_o` output 16: saturating count of dropped records.
- `level_o` output $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Qualify:** a commit is qualified when `update_i`=1 and `pc_i`≠0. Unqualified cycles change nothing.
- **Classify,** in priority order:
  - `memory_write_enable_i` → kind 3, using write address and data.
  - Otherwise, `memory_read_enable_i` and `reg_addr_i`≠0 → kind 2, with rd, `reg_data_i` and read address.
  - Otherwise, a load with rd=0 → kind 0.
  - Otherwise, `register_file_write_enable_i` and `reg_addr_i`≠0 → kind 1.
  - Otherwise → kind 0.
- **Store masking:** SW keeps 32 bits, SH keeps `[15:0]` zero-extended, SB keeps `[7:0]` zero-extended. Any other operation with write enable is stored as kind 3 with data 0.
- **Field zeroing:** fields unused by a kind are stored as 0 (rd, data, addr as applicable).
- **Sequence:** 32-bit `seq` counter increments on every qualified commit, dropped or not, and wraps 0xFFFFFFFF→0. Drops therefore appear as gaps in `trace_seq_o`.
- **FIFO:** circular buffer with read and write pointers one bit wider than the index.
  - Push = qualified commit and (not full, or a pop this cycle).
  - Pop = `trace_valid_o` & `trace_ready_i`.
- **Drop:** a qualified commit while full with no pop is dropped. It sets `overflow_o` and increments `drop_count_o`, saturating at 0xFFFF. Only `rst` clears either.
- **Outputs:** driven combinationally from the head entry. `trace_valid_o` = not empty. Head fields hold while valid and not ready.

## Timing
- **Reset:** while `rst` is high, all outputs are 0, pointers, `seq`, `overflow_o` and `drop_count_o` are 0, and the FIFO is empty. Storage contents need not be reset.
- **Latency:** a commit sampled at edge N is visible on `trace_*` after edge N (one cycle). There is no combinational bypass from `update_i` to `trace_valid_o`.
- **Throughput:** one push and one pop per cycle, sustained.
- **Full with simultaneous pop:** the push is accepted and `level_o` stays at DEPTH.
- **Empty:** a pop request cannot occur since valid=0, and the push takes effect normally.
- **Reset mid-stream:** `rst` asserting asynchronously discards all buffered records immediately. After release, the first qualified commit gets seq 0.
- **Handshake:** the sink may hold `trace_ready_i` high permanently, and the block must not depend on ready to assert valid.

## Test plan
- **Reset values:** hold `rst` 3 cycles with `update_i`=1 and pc=0x80000000; all outputs are 0 during reset. After release, the first record has seq=0 and valid rises one cycle after the commit.
- **Classification:**
  - addi with rd=5 and data 0x12 → kind 1, rd 5, data 0x00000012, addr 0.
  - Load rd=10 from 0x80001000 → kind 2.
  - Load with rd=0 → kind 0.
  - Commit with pc=0 → no record and no seq increment.
- **Store masking:** SB data 0xDEADBEEF → data 0x000000EF. SH → 0x0000BEEF. SW → 0xDEADBEEF. All are kind 3 with the address passed through.
- **Overflow:** ready=0, then 20 qualified commits with DEPTH=16 → `level_o`=16, `drop_count_o`=4, `overflow_o`=1. Draining yields seq 0–15, and the next accepted commit carries seq 20.
- **Full with simultaneous pop:** FIFO full, ready=1, commit each cycle for 50 cycles → no drops, `level_o` constant 16, output seqs contiguous.
- **Backpressure and async reset:** random ready, 1000 commits → output order and values match a scoreboard. Asserting `rst` mid-burst empties the FIFO immediately, before the next clock edge.
